// File: rtl/alu_v2_seq.sv
// alu_v2_seq: command sequencer that drives one ALU_v2 through clear/load/exec and returns its result.
// Optional macro ALU_SEQ_COEF_CACHE_EN skips clear/load when the immediates match the last loaded set.
module alu_v2_seq #(
  parameter int BUS_WIDTH = 8,
  parameter int EXEC_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [BUS_WIDTH-1:0] cmd_a,
  input  logic [BUS_WIDTH-1:0] cmd_b,
  input  logic [BUS_WIDTH-1:0] cmd_imm_b,
  input  logic [BUS_WIDTH-1:0] cmd_imm_d,
  input  logic [BUS_WIDTH-1:0] cmd_imm_e,
  output logic [BUS_WIDTH-1:0] alu_data_a,
  output logic [BUS_WIDTH-1:0] alu_data_b,
  output logic [BUS_WIDTH-1:0] alu_imm,
  output logic [2:0]           alu_reg_en,
  output logic                 alu_f_clr,
  input  logic [BUS_WIDTH-1:0] alu_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [BUS_WIDTH-1:0] res_data,
  output logic                 busy
);
  localparam int CW = $clog2(EXEC_CYC + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(EXEC_CYC - 1);
  typedef enum logic [2:0] {IDLE, CLR, LD_B, LD_D, LD_E, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic rdy_q;
  logic [BUS_WIDTH-1:0] a_q, a_d, b_q, b_d, ib_q, ib_d, id_q, id_d, ie_q, ie_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept, hit;
  // rdy_q keeps cmd_ready low until the first edge after reset release
  assign cmd_ready = rdy_q && state_q == IDLE;
  assign accept = cmd_valid && cmd_ready;
`ifdef ALU_SEQ_COEF_CACHE_EN
  logic cvld_q, cvld_d;
  logic [BUS_WIDTH-1:0] cb_q, cb_d, cd_q, cd_d, ce_q, ce_d;
  assign hit = cvld_q && cmd_imm_b == cb_q && cmd_imm_d == cd_q && cmd_imm_e == ce_q;
  always_comb begin
    cvld_d = cvld_q || state_q == LD_E;
    cb_d = state_q == LD_E ? ib_q : cb_q;
    cd_d = state_q == LD_E ? id_q : cd_q;
    ce_d = state_q == LD_E ? ie_q : ce_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cvld_q <= 1'b0;
      cb_q <= '0;
      cd_q <= '0;
      ce_q <= '0;
    end else begin
      cvld_q <= cvld_d;
      cb_q <= cb_d;
      cd_q <= cd_d;
      ce_q <= ce_d;
    end
`else
  assign hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    ib_d = ib_q;
    id_d = id_q;
    ie_d = ie_q;
    res_d = res_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        a_d = cmd_a;
        b_d = cmd_b;
        ib_d = cmd_imm_b;
        id_d = cmd_imm_d;
        ie_d = cmd_imm_e;
        cnt_d = CNT_INIT;
        state_d = hit ? EXEC : CLR;
      end
      CLR:  state_d = LD_B;
      LD_B: state_d = LD_D;
      LD_D: state_d = LD_E;
      LD_E: state_d = EXEC;
      EXEC: if (cnt_q == '0) begin
        res_d = alu_result;
        state_d = DONE;
      end else cnt_d = cnt_q - 1'b1;
      DONE: state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      ib_q <= '0;
      id_q <= '0;
      ie_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q <= 1'b1;
      a_q <= a_d;
      b_q <= b_d;
      ib_q <= ib_d;
      id_q <= id_d;
      ie_q <= ie_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  assign alu_f_clr = state_q == CLR;
  assign alu_reg_en = {state_q == LD_E, state_q == LD_D, state_q == LD_B};
  assign alu_imm = state_q == LD_B ? ib_q : state_q == LD_D ? id_q : state_q == LD_E ? ie_q : '0;
  assign alu_data_a = state_q == IDLE ? '0 : a_q;
  assign alu_data_b = state_q == IDLE ? '0 : b_q;
  assign res_valid = state_q == DONE;
  assign res_data = res_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_alu_v2_seq.sv
// tb_alu_v2_seq: directed checks of the sequencer with a constant-result ALU stub (EXEC_CYC 1 and 3).
module tb_alu_v2_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0, cmd_valid3 = 1'b0, res_ready = 1'b0, res_ready3 = 1'b0;
  logic [7:0] cmd_a = '0, cmd_b = '0, imm_b = '0, imm_d = '0, imm_e = '0;
  logic [7:0] alu_result = 8'h5A;
  logic cmd_ready, alu_f_clr, res_valid, busy;
  logic [7:0] alu_data_a, alu_data_b, alu_imm, res_data;
  logic [2:0] alu_reg_en;
  logic cmd_ready3, alu_f_clr3, res_valid3, busy3;
  logic [7:0] alu_data_a3, alu_data_b3, alu_imm3, res_data3;
  logic [2:0] alu_reg_en3;
  int checks = 0, errors = 0;
  alu_v2_seq #(.BUS_WIDTH(8), .EXEC_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_imm_b(imm_b), .cmd_imm_d(imm_d), .cmd_imm_e(imm_e),
    .alu_data_a(alu_data_a), .alu_data_b(alu_data_b), .alu_imm(alu_imm), .alu_reg_en(alu_reg_en),
    .alu_f_clr(alu_f_clr), .alu_result(alu_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy));
  alu_v2_seq #(.BUS_WIDTH(8), .EXEC_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_imm_b(imm_b), .cmd_imm_d(imm_d), .cmd_imm_e(imm_e),
    .alu_data_a(alu_data_a3), .alu_data_b(alu_data_b3), .alu_imm(alu_imm3), .alu_reg_en(alu_reg_en3),
    .alu_f_clr(alu_f_clr3), .alu_result(alu_result), .res_valid(res_valid3), .res_ready(res_ready3),
    .res_data(res_data3), .busy(busy3));
  wire [30:0] obs = {cmd_ready, busy, alu_f_clr, alu_reg_en, alu_imm, alu_data_a, alu_data_b, res_valid};
  wire [30:0] idle_vec = {1'b1, 30'b0};
`ifdef ALU_SEQ_COEF_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // cycle k counts from the accept cycle (k=0); a full run reaches DONE at k=6, a cache hit at k=2
  task automatic run1(input logic [7:0] a, b, ib, id, ie, input bit full, input int stall);
    int lat, s;
    logic [2:0] en;
    logic [7:0] im;
    lat = full ? 6 : 2;
    @(negedge clk);
    check("cmd_ready before cmd", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; imm_b = ib; imm_d = id; imm_e = ie;
    res_ready = stall == 0;
    for (int k = 1; k <= lat + stall; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0; cmd_a = ~a; cmd_b = ~b; imm_b = ~ib; imm_d = ~id; imm_e = ~ie;
      s = k > lat ? lat : k;
      en = !full ? 3'b000 : s == 2 ? 3'b001 : s == 3 ? 3'b010 : s == 4 ? 3'b100 : 3'b000;
      im = !full ? 8'h00 : s == 2 ? ib : s == 3 ? id : s == 4 ? ie : 8'h00;
      check($sformatf("seq k%0d", k), 64'(obs),
            64'({1'b0, 1'b1, full && s == 1, en, im, a, b, s == lat}));
      if (s == lat) check($sformatf("res_data k%0d", k), 64'(res_data), 64'h5A);
      if (k == lat + stall) res_ready = 1'b1;
    end
    @(negedge clk);
    check("back to idle", 64'(obs), 64'(idle_vec));
  endtask
  initial begin
    // T1: cmd_valid asserted during reset must not be taken
    cmd_valid = 1'b1; cmd_a = 8'h11; imm_b = 8'h22;
    repeat (2) @(negedge clk);
    check("reset outputs", 64'({obs, res_data}), 64'd0);
    rst_n = 1'b1; cmd_valid = 1'b0;
    #1 check("ready low at release", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("idle after release", 64'({obs, res_data}), 64'({idle_vec, 8'h00}));
    // T2: full sequence, res_ready already high
    run1(8'd3, 8'd4, 8'd2, 8'd5, 8'd7, 1'b1, 0);
    // T3: consumer stalls 10 cycles in DONE
    run1(8'h10, 8'h20, 8'h31, 8'h32, 8'h33, 1'b1, 10);
    // T4: reset while in LD_D
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 8'h66; cmd_b = 8'h77; imm_b = 8'h41; imm_d = 8'h42; imm_e = 8'h43;
    res_ready = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("in LD_D", 64'({alu_reg_en, alu_imm}), 64'({3'b010, 8'h42}));
    #1 rst_n = 1'b0;
    #1 check("async abort", 64'({obs, res_data}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0 || k == 7) check($sformatf("no result after abort %0d", k), 64'(obs), 64'(idle_vec));
    end
    run1(8'h05, 8'h06, 8'h51, 8'h52, 8'h53, 1'b1, 0);
    // T5: EXEC_CYC=3 instance, result in the 8th cycle
    @(negedge clk);
    cmd_valid3 = 1'b1; res_ready3 = 1'b1;
    cmd_a = 8'h21; cmd_b = 8'h43; imm_b = 8'h01; imm_d = 8'h02; imm_e = 8'h03;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      cmd_valid3 = 1'b0;
      check($sformatf("e3 res_valid k%0d", k), 64'(res_valid3), 64'(k == 8));
      if (k == 4) check("e3 ld_e", 64'({alu_reg_en3, alu_imm3}), 64'({3'b100, 8'h03}));
      if (k >= 5 && k <= 7)
        check($sformatf("e3 exec k%0d", k), 64'({alu_f_clr3, alu_reg_en3, alu_imm3, alu_data_a3, alu_data_b3, busy3}),
              64'({1'b0, 3'b000, 8'h00, 8'h21, 8'h43, 1'b1}));
      if (k == 8) check("e3 res_data", 64'(res_data3), 64'h5A);
    end
    // T6: repeated immediates hit the cache only when it is built in
    run1(8'h81, 8'h82, 8'h0B, 8'h0D, 8'h0E, 1'b1, 0);
    run1(8'h91, 8'h92, 8'h0B, 8'h0D, 8'h0E, !CACHE, 0);
    run1(8'h91, 8'h92, 8'h0B, 8'h0D, 8'h08, 1'b1, 0);
    run1(8'hA1, 8'hA2, 8'h0B, 8'h0D, 8'h08, !CACHE, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
